// File: rtl/pll_clken_pkg.sv
// Shared types and helpers for the PLL-domain fractional clock-enable generator.
// Lock-qualification states plus a width helper that never returns zero.
package pll_clken_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        SETTLE    = 2'd1,
        RUN       = 2'd2
    } state_t;

    // Bits needed to index n items; at least 1 so single-entry ports stay legal.
    function automatic int clog2_min1(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pll_clken_nco.sv
// One NCO channel: phase accumulator, active increment, shadow increment, carry enable.
// Latency: clken is registered, one cycle after the accumulator carry is produced.
// Backpressure: none; shadow writes are always accepted and apply at the next carry.
// Optional CLKEN_SQUARE_OUT_EN adds a registered MSB square-wave output.
import pll_clken_pkg::*;

module pll_clken_nco #(
    parameter int ACC_W = 32
) (
    input  logic             refclk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             phase_sync,
    input  logic             wr_en,
    input  logic [ACC_W-1:0] wr_inc,
    output logic             clken
`ifdef CLKEN_SQUARE_OUT_EN
    ,
    output logic             clk_sq
`endif
);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] inc;
    logic [ACC_W-1:0] shadow;
    logic [ACC_W:0]   sum;
    logic             carry;
    logic             xfer;
    logic             zero_acc;

    assign sum      = {1'b0, acc} + {1'b0, inc};
    assign carry    = sum[ACC_W];
    assign zero_acc = !run || phase_sync;

    // Swap increments only at a period boundary so no enable period is shortened;
    // an idle channel (not running or inc=0) has no boundary and swaps at once.
    assign xfer = zero_acc || (inc == '0) || carry;

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            inc    <= '0;
            shadow <= '0;
            clken  <= 1'b0;
        end else begin
            if (wr_en) begin
                shadow <= wr_inc;
            end
            if (xfer) begin
                inc <= shadow;
            end
            if (zero_acc) begin
                acc   <= '0;
                clken <= 1'b0;
            end else begin
                acc   <= sum[ACC_W-1:0];
                clken <= carry;
            end
        end
    end

`ifdef CLKEN_SQUARE_OUT_EN
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sq <= 1'b0;
        end else if (zero_acc) begin
            clk_sq <= 1'b0;
        end else begin
            clk_sq <= acc[ACC_W-1];
        end
    end
`endif

endmodule

// File: rtl/pll_clken_gen.sv
// Multi-channel fractional clock-enable generator gated by a synchronised, debounced PLL lock.
// Latency: ready rises SYNC_STAGES+LOCK_CYCLES+1 cycles after lock; clken registered per channel.
// Backpressure: none; config writes accepted in any state. CLKEN_SQUARE_OUT_EN adds clk_sq.
import pll_clken_pkg::*;

module pll_clken_gen #(
    parameter int NUM_CH      = 4,
    parameter int ACC_W       = 32,
    parameter int LOCK_CYCLES = 1024,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          refclk,
    input  logic                          rst_n,
    input  logic                          pll_locked,
    input  logic                          cfg_we,
    input  logic [clog2_min1(NUM_CH)-1:0] cfg_ch,
    input  logic [ACC_W-1:0]              cfg_inc,
    input  logic                          phase_sync,
    output logic [NUM_CH-1:0]             clken,
    output logic                          ready
`ifdef CLKEN_SQUARE_OUT_EN
    ,
    output logic [NUM_CH-1:0]             clk_sq
`endif
);

    localparam int CH_W  = clog2_min1(NUM_CH);
    localparam int CNT_W = clog2_min1(LOCK_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_lock;
    state_t                 state;
    state_t                 state_nx;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cnt_nx;
    logic                   run;

    assign sync_lock = sync_q[SYNC_STAGES-1];

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
        end
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
            ready <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            ready <= (state_nx == RUN);
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            WAIT_LOCK: begin
                cnt_nx = '0;
                if (sync_lock) begin
                    state_nx = SETTLE;
                end
            end
            SETTLE: begin
                if (!sync_lock) begin
                    state_nx = WAIT_LOCK;
                    cnt_nx   = '0;
                end else if (cnt == CNT_MAX) begin
                    state_nx = RUN;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            RUN: begin
                if (!sync_lock) begin
                    state_nx = WAIT_LOCK;
                end
            end
            default: begin
                state_nx = WAIT_LOCK;
                cnt_nx   = '0;
            end
        endcase
    end

    // Losing lock in RUN must clear the channels on the same edge that leaves RUN.
    assign run = (state == RUN) && sync_lock;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        pll_clken_nco #(
            .ACC_W (ACC_W)
        ) u_nco (
            .refclk     (refclk),
            .rst_n      (rst_n),
            .run        (run),
            .phase_sync (phase_sync),
            .wr_en      (cfg_we && (cfg_ch == CH_W'(i))),
            .wr_inc     (cfg_inc),
            .clken      (clken[i])
`ifdef CLKEN_SQUARE_OUT_EN
            ,
            .clk_sq     (clk_sq[i])
`endif
        );
    end

endmodule
